matmul_seq: RTL and testbench

Sequencer that drives the shared byte-wide data memory to compute C = A·B. On `start` it reads the problem header (m, n, l, A base, C base) from fixed memory locations, streams A and B elements through a single 8×8 multiply-accumulate, and writes each 16-bit result of C back through the memory's 16-bit write port. It sits directly upstream of the data memory and owns all of that memory's port signals while `busy` is high.

---
 rtl/matmul_seq_if.sv | 26 ++
 rtl/matmul_seq.sv | 156 +++++++++++++++
 tb/tb_matmul_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/matmul_seq_if.sv
// Memory-side and control bus of the matmul sequencer.
// The master drives the memory port and the status; the slave supplies start and read data.
// No handshake: read data is valid one cycle after the address is presented.
interface matmul_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      mem_we;
    logic [2*DATA_WIDTH-1:0]   mem_w_data;
    logic [ADDR_WIDTH-1:0]     mem_w_addr;
    logic [ADDR_WIDTH-1:0]     mem_r_addr;
    logic [DATA_WIDTH-1:0]     mem_r_data;

    modport master (
        input  start, mem_r_data,
        output busy, done, mem_we, mem_w_data, mem_w_addr, mem_r_addr
    );

    modport slave (
        output start, mem_r_data,
        input  busy, done, mem_we, mem_w_data, mem_w_addr, mem_r_addr
    );
endinterface

// File: rtl/matmul_seq.sv
// Sequencer computing C = A*B out of a byte-wide memory through one 8x8 MAC.
// Latency: 7 + m*l*(3n+1) cycles from the start edge to the done pulse (7 if any dimension is 0).
// No backpressure: the memory answers every read one cycle later and accepts every write.
module matmul_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    matmul_seq_if.master  bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SETUP, S_RD_A, S_RD_B, S_MAC, S_WR, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      hcnt;
    logic [DW-1:0]   dim_m, dim_n, dim_l;
    logic [AW-1:0]   base_a, base_b, base_c;
    logic [DW-1:0]   i, j, k;
    logic [DW-1:0]   a_byte;
    logic [PW-1:0]   acc;

    logic [AW-1:0]   hdr_addr;
    logic [AW-1:0]   addr_a, addr_b, addr_c;
    logic            k_last, j_last, i_last, zero_dim;

    // Element addresses: all arithmetic intentionally wraps at the address width.
    assign addr_a = base_a + ((AW'(i) * AW'(dim_n) + AW'(k)) << 1);
    assign addr_b = base_b + ((AW'(k) * AW'(dim_l) + AW'(j)) << 1);
    assign addr_c = base_c + ((AW'(i) * AW'(dim_l) + AW'(j)) << 1);

    assign k_last   = (k == dim_n - DW'(1));
    assign j_last   = (j == dim_l - DW'(1));
    assign i_last   = (i == dim_m - DW'(1));
    assign zero_dim = (dim_m == '0) || (dim_n == '0) || (dim_l == '0);

    // Fixed header locations: m, n, l, base_a, base_c.
    always_comb begin
        hdr_addr = '0;
        case (hcnt)
            3'd0:    hdr_addr = AW'(0);
            3'd1:    hdr_addr = AW'(2);
            3'd2:    hdr_addr = AW'(4);
            3'd3:    hdr_addr = AW'(12);
            3'd4:    hdr_addr = AW'(14);
            default: hdr_addr = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and memory-port outputs, decoded straight from the state so reset clears them at once.
    always_comb begin
        state_nxt       = state;
        bus.busy        = (state != S_IDLE);
        bus.done        = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_w_data  = '0;
        bus.mem_w_addr  = '0;
        bus.mem_r_addr  = '0;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_HDR;
            S_HDR: begin
                bus.mem_r_addr = hdr_addr;
                if (hcnt == 3'd5) state_nxt = S_SETUP;
            end
            S_SETUP: state_nxt = zero_dim ? S_DONE : S_RD_A;
            S_RD_A: begin
                bus.mem_r_addr = addr_a;
                state_nxt      = S_RD_B;
            end
            S_RD_B: begin
                bus.mem_r_addr = addr_b;
                state_nxt      = S_MAC;
            end
            S_MAC:   state_nxt = k_last ? S_WR : S_RD_A;
            S_WR: begin
                bus.mem_we     = 1'b1;
                bus.mem_w_addr = addr_c;
                bus.mem_w_data = acc;
                state_nxt      = (i_last && j_last) ? S_DONE : S_RD_A;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Header capture, loop counters and the multiply-accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            dim_m  <= '0;
            dim_n  <= '0;
            dim_l  <= '0;
            base_a <= '0;
            base_b <= '0;
            base_c <= '0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            a_byte <= '0;
            acc    <= '0;
        end else begin
            case (state)
                S_IDLE: hcnt <= '0;
                S_HDR: begin
                    hcnt <= hcnt + 3'd1;
                    // Data for the address issued at hcnt-1 arrives now.
                    case (hcnt)
                        3'd1:    dim_m  <= bus.mem_r_data;
                        3'd2:    dim_n  <= bus.mem_r_data;
                        3'd3:    dim_l  <= bus.mem_r_data;
                        3'd4:    base_a <= AW'(bus.mem_r_data);
                        3'd5:    base_c <= AW'(bus.mem_r_data);
                        default: ;
                    endcase
                end
                S_SETUP: begin
                    base_b <= base_a + ((AW'(dim_m) * AW'(dim_n)) << 1);
                    i      <= '0;
                    j      <= '0;
                    k      <= '0;
                    acc    <= '0;
                end
                S_RD_B: a_byte <= bus.mem_r_data;
                S_MAC: begin
                    acc <= acc + PW'(a_byte) * PW'(bus.mem_r_data);
                    if (!k_last) k <= k + DW'(1);
                end
                S_WR: begin
                    acc <= '0;
                    k   <= '0;
                    if (j_last) begin
                        j <= '0;
                        i <= i + DW'(1);
                    end else begin
                        j <= j + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: byte memory model plus a plain matrix-product reference.
// Directed cases from the feature list, then randomized shapes, bases and element values.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_matmul_seq;
    localparam int DW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    matmul_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Byte memory with registered read and a 16-bit write port.
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       ld_all = 1'b0;
    logic [7:0] w_addr_hi;
    assign w_addr_hi = bus.mem_w_addr + 8'd1;

    // Memory model: bulk image load from the bench, else DUT writes; reads always registered.
    always @(posedge clk) begin
        if (ld_all) begin
            for (int a = 0; a < 256; a++) mem[a] <= img[a];
        end else if (bus.mem_we) begin
            mem[bus.mem_w_addr] <= bus.mem_w_data[7:0];
            mem[w_addr_hi]      <= bus.mem_w_data[15:8];
        end
        bus.mem_r_data <= mem[bus.mem_r_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    int ma [16];
    int mb [16];
    int exp_addr [$];
    int exp_data [$];

    // One run: build memory, compute the reference product, start, observe every cycle.
    task automatic run_case(input int m, input int n, input int l, input int ba, input int bc,
                            input int repulse, input int abort_cyc);
        int  bb, sum, exp_done, done_cyc, nw;
        bit  zero, aborted;
        for (int a = 0; a < 256; a++) img[a] = 8'd0;
        img[0]  = 8'(m);
        img[2]  = 8'(n);
        img[4]  = 8'(l);
        img[12] = 8'(ba);
        img[14] = 8'(bc);
        bb = (ba + 2 * m * n) % 256;
        for (int i = 0; i < m; i++)
            for (int k = 0; k < n; k++)
                img[(ba + 2 * (i * n + k)) % 256] = 8'(ma[i * n + k]);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < l; j++)
                img[(bb + 2 * (k * l + j)) % 256] = 8'(mb[k * l + j]);

        exp_addr.delete();
        exp_data.delete();
        zero = (m == 0) || (n == 0) || (l == 0);
        if (!zero) begin
            for (int i = 0; i < m; i++)
                for (int j = 0; j < l; j++) begin
                    sum = 0;
                    for (int k = 0; k < n; k++) sum += ma[i * n + k] * mb[k * l + j];
                    exp_addr.push_back((bc + 2 * (i * l + j)) % 256);
                    exp_data.push_back(sum % 65536);
                end
        end
        exp_done = zero ? 7 : 7 + m * l * (3 * n + 1);

        ld_all = 1'b1;
        @(posedge clk);
        #1 ld_all = 1'b0;
        @(negedge clk);
        check("busy_idle", bus.busy, 0);

        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;

        done_cyc = -1;
        nw = 0;
        aborted = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == 0) check("busy_after_start", bus.busy, 1);
            if (c == repulse) bus.start = 1'b1;
            else if (c == repulse + 1) bus.start = 1'b0;
            if (c == abort_cyc) begin
                check("abort_in_rd_b_addr", bus.mem_r_addr, (bb + 2) % 256);
                rst_n = 1'b0;
                #1;
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_we", bus.mem_we, 0);
                check("rst_w_data", bus.mem_w_data, 0);
                check("rst_w_addr", bus.mem_w_addr, 0);
                check("rst_r_addr", bus.mem_r_addr, 0);
                check("partial_c_kept", mem[exp_addr[0]], exp_data[0] % 256);
                aborted = 1'b1;
                break;
            end
            if (bus.mem_we) begin
                if (nw < exp_addr.size()) begin
                    check("w_addr", bus.mem_w_addr, exp_addr[nw]);
                    check("w_data", bus.mem_w_data, exp_data[nw]);
                end
                nw++;
            end
            if (bus.done) begin
                done_cyc = c;
                break;
            end
        end

        if (!aborted) begin
            check("done_cycle", done_cyc, exp_done);
            check("write_count", nw, exp_addr.size());
            @(negedge clk);
            check("busy_after_done", bus.busy, 0);
            check("done_one_cycle", bus.done, 0);
            for (int e = 0; e < exp_addr.size(); e++) begin
                check("mem_lo", mem[exp_addr[e]], exp_data[e] % 256);
                check("mem_hi", mem[(exp_addr[e] + 1) % 256], exp_data[e] / 256);
            end
        end
    endtask

    task automatic load_test1();
        for (int x = 0; x < 6; x++) begin
            ma[x] = x + 1;
            mb[x] = x + 7;
        end
    endtask

    initial begin
        int m, n, l, ba, bc;
        bus.start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_we", bus.mem_we, 0);
        check("reset_w_data", bus.mem_w_data, 0);
        check("reset_w_addr", bus.mem_w_addr, 0);
        check("reset_r_addr", bus.mem_r_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2x3 by 3x2 reference problem.
        load_test1();
        run_case(2, 3, 2, 16, 150, -1, -1);

        // Accumulator wrap.
        ma[0] = 255; ma[1] = 255; mb[0] = 255; mb[1] = 255;
        run_case(1, 2, 1, 16, 100, -1, -1);

        // Zero inner dimension.
        run_case(2, 0, 3, 16, 150, -1, -1);

        // Result written across the top of the address space.
        ma[0] = 3; mb[0] = 5;
        run_case(1, 1, 1, 16, 254, -1, -1);

        // start re-asserted during a MAC cycle is ignored.
        load_test1();
        run_case(2, 3, 2, 16, 150, 9, -1);

        // Reset in RD_B of the second element, then a clean rerun.
        run_case(2, 3, 2, 16, 150, -1, 18);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_case(2, 3, 2, 16, 150, -1, -1);

        // Randomized shapes and contents, regions kept disjoint.
        for (int t = 0; t < 25; t++) begin
            m  = $urandom_range(0, 4);
            n  = $urandom_range(0, 4);
            l  = $urandom_range(0, 4);
            if (t % 8 != 0) begin
                if (m == 0) m = 1;
                if (n == 0) n = 1;
                if (l == 0) l = 1;
            end
            ba = 16 + 2 * $urandom_range(0, 32);
            bc = 150 + 2 * $urandom_range(0, 20);
            for (int x = 0; x < 16; x++) begin
                ma[x] = $urandom_range(0, 255);
                mb[x] = $urandom_range(0, 255);
            end
            run_case(m, n, l, ba, bc, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
